// File: rtl/traffic_sensor_conditioner.sv
//==============================================================================
// Module   : traffic_sensor_conditioner
// Purpose  : Front end for the traffic-light controller. Synchronizes and
//            debounces the raw road sensors, generates the one-cycle step
//            enable (tick) that paces the controller FSM on the fast clock,
//            and presents sensor values held constant for a whole tick period.
//
// Ports    : clk       in   system clock
//            reset     in   asynchronous, active-high reset
//            sa_raw    in   raw road-A sensor (asynchronous, may bounce)
//            sb_raw    in   raw road-B sensor (asynchronous, may bounce)
//            tick      out  one-cycle pulse, once every TICK_DIV cycles
//            sa        out  road-A traffic present, held for the tick period
//            sb        out  road-B traffic present, held for the tick period
//            sa_clean  out  live debounced road-A sensor (status/debug)
//            sb_clean  out  live debounced road-B sensor (status/debug)
//
// Parameters: TICK_DIV   clk cycles per tick period (>= 2)
//             DEB_CYCLES stable synchronized cycles to accept a change (>= 1)
//
// Build option: SENSOR_STICKY_EN
//            Defined   -> a sensor seen clean-high at any point in a window is
//                         reported on sa/sb for the whole next period.
//            Undefined -> sa/sb sample the debounced sensor on the latch edge.
//
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module traffic_sensor_conditioner #(
    parameter int TICK_DIV   = 200000000,
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic tick,
    output logic sa,
    output logic sb,
    output logic sa_clean,
    output logic sb_clean
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES) + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    // Elaboration-time guard on the legal parameter range.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("traffic_sensor_conditioner: TICK_DIV must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("traffic_sensor_conditioner: DEB_CYCLES must be >= 1");
    end

    //--------------------------------------------------------------------------
    // Tick generator: free-running modulo-TICK_DIV counter. The tick flop is
    // loaded on the same edge the counter wraps, so tick is high in the cycle
    // following the TICK_DIV-th edge after reset release.
    //--------------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick_q;
    logic          tick_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        tick_d     = 1'b0;
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;

    //--------------------------------------------------------------------------
    // Per-sensor path: index 0 is road A, index 1 is road B. The two lanes are
    // fully independent and may change, debounce and latch on the same edge.
    //--------------------------------------------------------------------------
    logic [1:0] raw_w;
    logic [1:0] clean_w;
    logic [1:0] held_w;

    assign raw_w = {sb_raw, sa_raw};

    for (genvar i = 0; i < 2; i++) begin : g_sensor
        logic          s1_q;
        logic          s2_q;
        logic          clean_q;
        logic          clean_d;
        logic [DW-1:0] deb_cnt_q;
        logic [DW-1:0] deb_cnt_d;
        logic          held_q;
        logic          held_d;

        // Debounce: count consecutive cycles where the synchronized level
        // disagrees with the accepted one. Any agreement restarts the run.
        always_comb begin
            clean_d   = clean_q;
            deb_cnt_d = deb_cnt_q + DW'(1);
            if (s2_q == clean_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                clean_d   = s2_q;
                deb_cnt_d = '0;
            end
        end

`ifdef SENSOR_STICKY_EN
        // Sticky flag remembers any clean-high seen during the window. On the
        // latch edge the live clean value is OR-ed in as well, since the flag
        // itself only reflects edges before this one.
        logic flag_q;
        logic flag_d;

        always_comb begin
            flag_d = flag_q | clean_q;
            held_d = held_q;
            if (tick_d) begin
                held_d = flag_q | clean_q;
                flag_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= flag_d;
            end
        end
`else
        // Without the sticky flag the held output is a plain sample of the
        // debounced sensor; a car present only mid-window is not reported.
        always_comb begin
            held_d = held_q;
            if (tick_d) begin
                held_d = clean_q;
            end
        end
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                clean_q   <= 1'b0;
                deb_cnt_q <= '0;
                held_q    <= 1'b0;
            end else begin
                s1_q      <= raw_w[i];
                s2_q      <= s1_q;
                clean_q   <= clean_d;
                deb_cnt_q <= deb_cnt_d;
                held_q    <= held_d;
            end
        end

        assign clean_w[i] = clean_q;
        assign held_w[i]  = held_q;
    end

    assign sa_clean = clean_w[0];
    assign sb_clean = clean_w[1];
    assign sa       = held_w[0];
    assign sb       = held_w[1];

endmodule

`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
`timescale 1ns/1ps

module tb_traffic_sensor_conditioner;

    localparam int TICK_DIV   = 32;
    localparam int DEB_CYCLES = 4;

`ifdef SENSOR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic reset;
    logic sa_raw;
    logic sb_raw;
    logic tick;
    logic sa;
    logic sb;
    logic sa_clean;
    logic sb_clean;

    int checks;
    int errors;
    int edge_n;

    traffic_sensor_conditioner #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sa_raw   (sa_raw),
        .sb_raw   (sb_raw),
        .tick     (tick),
        .sa       (sa),
        .sb       (sb),
        .sa_clean (sa_clean),
        .sb_clean (sb_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; sample and drive 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Reset with both raw inputs low; edge_n counts edges after release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    function automatic bit tick_exp(int e);
        return (e > 0) && (e % TICK_DIV == 0);
    endfunction

    // Reset state, then idle ticking with quiet sensors.
    task automatic test_reset();
        logic [4:0] got;
        logic [4:0] exp;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        #1;
        got = {tick, sa, sb, sa_clean, sb_clean};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", got, 5'b0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), 4'b0000};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL idle_tick edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    // sa_raw rises before edge 3: sa_clean after edge 8, sa from tick at 32.
    task automatic test_sa_steady();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step();
            if (edge_n == 2) sa_raw = 1'b1;
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), (edge_n >= 32), 1'b0, (edge_n >= 8), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sa_steady edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    // 3-cycle glitch on sb (edges 10-12) is rejected; 5-cycle pulse
    // (edges 20-24) gives sb_clean high after edges 25..29.
    task automatic test_sb_glitch();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 70; k++) begin
            step();
            if (edge_n == 9)  sb_raw = 1'b1;
            if (edge_n == 12) sb_raw = 1'b0;
            if (edge_n == 19) sb_raw = 1'b1;
            if (edge_n == 24) sb_raw = 1'b0;
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), 1'b0,
                   STICKY && (edge_n >= 32) && (edge_n < 64),
                   1'b0, (edge_n >= 25) && (edge_n <= 29)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sb_glitch edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    // sa_raw sampled high at edges 40..47: sa_clean high after 45..52.
    // Sticky build reports sa for the period 64..95; otherwise never.
    task automatic test_mid_window();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step();
            if (edge_n == 39) sa_raw = 1'b1;
            if (edge_n == 47) sa_raw = 1'b0;
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n),
                   STICKY && (edge_n >= 64) && (edge_n < 96), 1'b0,
                   (edge_n >= 45) && (edge_n <= 52), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_window edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    // Both raw inputs rise together before edge 5.
    task automatic test_simultaneous();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step();
            if (edge_n == 4) begin
                sa_raw = 1'b1;
                sb_raw = 1'b1;
            end
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), (edge_n >= 32), (edge_n >= 32),
                   (edge_n >= 10), (edge_n >= 10)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simultaneous edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    // Async reset between edges at cnt=20 with sa=1, then recovery.
    task automatic test_async_reset();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        sa_raw = 1'b1;
        for (int k = 0; k < 52; k++) begin
            step();
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), (edge_n >= 32), 1'b0, (edge_n >= 6), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_async edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        got = {tick, sa, sb, sa_clean, sb_clean};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", got, 5'b0);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            got = {tick, sa, sb, sa_clean, sb_clean};
            exp = {tick_exp(edge_n), (edge_n >= 32), 1'b0, (edge_n >= 6), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_async edge=%0d got=%b exp=%b", edge_n, got, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        reset  = 1'b1;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        test_reset();
        test_sa_steady();
        test_sb_glitch();
        test_mid_window();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
